rom_dl_sched: RTL

- Sequences the HPS ROM download stream into the SEGA System 1 core's ROM write port.
- Buffers ioctl bytes in a small FIFO and throttles the HPS with ioctl_wait when the ROM sink stalls.
- Decodes the linear download address into region select plus region offset.
- Latches the game number from index-1 downloads and owns the core reset sequence around a download.

---
 rtl/sys1_dl_pkg.sv | 77 +++++++
 rtl/dl_fifo.sv | 59 +++++
 rtl/rom_dl_sched.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/sys1_dl_pkg.sv
// sys1_dl_pkg: shared types and constants for the System 1 ROM download path.
//   - rom_region_e : ROM sink region select (CPU, SND, TILE, SPR, PROM)
//   - *_BASE/*_LAST: inclusive linear address window of each region
//   - dl_state_e   : download sequencer state
//   - dl_entry_t   : byte FIFO entry layout {region, offset, data} at DL_AW
//   - dl_decode()  : linear address -> {hit, region, offset}
package sys1_dl_pkg;

  localparam int DL_AW = 17;

  typedef enum logic [2:0] {
    RGN_CPU  = 3'd0,
    RGN_SND  = 3'd1,
    RGN_TILE = 3'd2,
    RGN_SPR  = 3'd3,
    RGN_PROM = 3'd4
  } rom_region_e;

  localparam logic [24:0] CPU_BASE  = 25'h000_0000;
  localparam logic [24:0] CPU_LAST  = 25'h000_FFFF;
  localparam logic [24:0] SND_BASE  = 25'h001_0000;
  localparam logic [24:0] SND_LAST  = 25'h001_1FFF;
  localparam logic [24:0] TILE_BASE = 25'h001_2000;
  localparam logic [24:0] TILE_LAST = 25'h002_9FFF;
  localparam logic [24:0] SPR_BASE  = 25'h002_A000;
  localparam logic [24:0] SPR_LAST  = 25'h003_9FFF;
  localparam logic [24:0] PROM_BASE = 25'h003_A000;
  localparam logic [24:0] PROM_LAST = 25'h003_A2FF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } dl_state_e;

  typedef struct packed {
    rom_region_e       region;
    logic [DL_AW-1:0]  offset;
    logic [7:0]        data;
  } dl_entry_t;

  typedef struct packed {
    logic              hit;
    rom_region_e       region;
    logic [DL_AW-1:0]  offset;
  } dl_decode_t;

  // The regions tile the image contiguously from address 0, so a chain of
  // upper-bound compares is enough to pick the region.
  function automatic dl_decode_t dl_decode(input logic [24:0] addr);
    dl_decode_t d;
    d.hit    = 1'b1;
    d.region = RGN_CPU;
    d.offset = '0;
    if (addr <= CPU_LAST) begin
      d.region = RGN_CPU;
      d.offset = DL_AW'(addr - CPU_BASE);
    end else if (addr <= SND_LAST) begin
      d.region = RGN_SND;
      d.offset = DL_AW'(addr - SND_BASE);
    end else if (addr <= TILE_LAST) begin
      d.region = RGN_TILE;
      d.offset = DL_AW'(addr - TILE_BASE);
    end else if (addr <= SPR_LAST) begin
      d.region = RGN_SPR;
      d.offset = DL_AW'(addr - SPR_BASE);
    end else if (addr <= PROM_LAST) begin
      d.region = RGN_PROM;
      d.offset = DL_AW'(addr - PROM_BASE);
    end else begin
      d.hit = 1'b0;
    end
    return d;
  endfunction

endpackage

// File: rtl/dl_fifo.sv
// dl_fifo: synchronous single-clock FIFO.
//   clk_sys, reset_n : clock, synchronous active-low reset (empties the FIFO)
//   push, push_data  : write strobe and word; ignored while full
//   pop              : discard the head word; ignored while empty
//   head             : word at the read pointer (valid while !empty)
//   count, full, empty : occupancy status
// DEPTH must be a power of two so the pointers wrap naturally.
module dl_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 28
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_sys) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/rom_dl_sched.sv
// rom_dl_sched: sequences the HPS ROM download into the core's ROM write port.
//   clk_sys, reset_n        : clock, synchronous active-low reset
//   ioctl_download/wr/index/addr/dout : HPS download stream
//   ioctl_wait              : registered throttle, high while occupancy >= WAIT_LVL
//   rom_we/region/addr/data : write request to the ROM sink, held until rom_rdy
//   rom_rdy                 : sink accepts the presented write this cycle
//   core_rst                : game core reset, high from download start until
//                             RST_HOLD cycles after the FIFO drains
//   game_no                 : game number from index-1 downloads
//   dl_done                 : one-cycle pulse when core_rst is released
//   err_ovf, err_range      : sticky drop flags (FIFO full / address outside regions)
//
// Sink handshake: rom_we and the region/addr/data bundle are a valid/ready pair;
// once rom_we is high, the bundle is frozen until a cycle with rom_we & rom_rdy,
// which pops the FIFO. rom_we then drops for one cycle before the next head.
// RST_HOLD must be at least 2.
module rom_dl_sched
  import sys1_dl_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int WAIT_LVL   = 2,
  parameter int RST_HOLD   = 16,
  parameter int AW         = 17
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          ioctl_download,
  input  logic          ioctl_wr,
  input  logic [7:0]    ioctl_index,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          rom_we,
  input  logic          rom_rdy,
  output logic [2:0]    rom_region,
  output logic [AW-1:0] rom_addr,
  output logic [7:0]    rom_data,
  output logic          core_rst,
  output logic [7:0]    game_no,
  output logic          dl_done,
  output logic          err_ovf,
  output logic          err_range
);

  localparam int EW  = 3 + AW + 8;
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int HCW = $clog2(RST_HOLD + 1);

  // ---------------------------------------------------------------------------
  // Byte acceptance and address decode
  // ---------------------------------------------------------------------------
  dl_decode_t     dec;
  logic           byte_rom;
  logic           push_req;
  logic           fifo_push;
  logic           fifo_pop;
  logic [EW-1:0]  push_word;
  logic [EW-1:0]  fifo_head;
  logic [CW-1:0]  fifo_count;
  logic           fifo_full;
  logic           fifo_empty;

  assign dec       = dl_decode(ioctl_addr);
  assign byte_rom  = ioctl_download & ioctl_wr & (ioctl_index == 8'd0);
  assign push_req  = byte_rom & dec.hit;
  assign fifo_push = push_req & ~fifo_full;
  assign fifo_pop  = rom_we & rom_rdy;
  assign push_word = {dec.region, AW'(dec.offset), ioctl_dout};

  dl_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (EW)
  ) u_fifo (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (push_word),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Head presentation. The entry stays in the FIFO while presented, so
  // occupancy counts it. With an empty FIFO the byte being pushed is loaded
  // straight into the output register, giving rom_we the cycle after the push.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      rom_we     <= 1'b0;
      rom_region <= '0;
      rom_addr   <= '0;
      rom_data   <= '0;
    end else if (rom_we && rom_rdy) begin
      rom_we <= 1'b0;
    end else if (!rom_we) begin
      if (!fifo_empty) begin
        rom_we                           <= 1'b1;
        {rom_region, rom_addr, rom_data} <= fifo_head;
      end else if (fifo_push) begin
        rom_we                           <= 1'b1;
        {rom_region, rom_addr, rom_data} <= push_word;
      end
    end
  end

  // Throttle and sticky error flags
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      ioctl_wait <= 1'b0;
      err_ovf    <= 1'b0;
      err_range  <= 1'b0;
    end else begin
      ioctl_wait <= (fifo_count >= CW'(WAIT_LVL));
      if (push_req && fifo_full) err_ovf   <= 1'b1;
      if (byte_rom && !dec.hit)  err_range <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Download sequencer
  // ---------------------------------------------------------------------------
  dl_state_e        state;
  dl_state_e        state_nxt;
  logic [HCW-1:0]   hold_cnt;
  logic [HCW-1:0]   hold_cnt_nxt;
  logic             core_rst_nxt;
  logic             dl_done_nxt;
  logic             enter_load;
  logic             dl_q;
  logic             rom_dl_rise;
  logic             drained;

  assign rom_dl_rise = ioctl_download & ~dl_q & (ioctl_index == 8'd0);
  assign drained     = fifo_empty & ~rom_we;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      core_rst <= 1'b1;
      dl_done  <= 1'b0;
      dl_q     <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_cnt_nxt;
      core_rst <= core_rst_nxt;
      dl_done  <= dl_done_nxt;
      dl_q     <= ioctl_download;
    end
  end

  // The cycle in DRAIN that first sees the drained condition counts as the
  // first hold cycle, so core_rst drops exactly RST_HOLD cycles after it.
  always_comb begin
    state_nxt    = state;
    hold_cnt_nxt = hold_cnt;
    core_rst_nxt = core_rst;
    dl_done_nxt  = 1'b0;
    enter_load   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rom_dl_rise) begin
          state_nxt    = ST_LOAD;
          core_rst_nxt = 1'b1;
          enter_load   = 1'b1;
        end
      end
      ST_LOAD: begin
        core_rst_nxt = 1'b1;
        if (!ioctl_download) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        core_rst_nxt = 1'b1;
        if (rom_dl_rise) begin
          state_nxt    = ST_LOAD;
          hold_cnt_nxt = '0;
          enter_load   = 1'b1;
        end else if (drained) begin
          state_nxt    = ST_HOLD;
          hold_cnt_nxt = HCW'(1);
        end
      end
      ST_HOLD: begin
        core_rst_nxt = 1'b1;
        if (rom_dl_rise) begin
          state_nxt    = ST_LOAD;
          hold_cnt_nxt = '0;
          enter_load   = 1'b1;
        end else if (hold_cnt == HCW'(RST_HOLD - 1)) begin
          state_nxt    = ST_IDLE;
          hold_cnt_nxt = '0;
          core_rst_nxt = 1'b0;
          dl_done_nxt  = 1'b1;
        end else begin
          hold_cnt_nxt = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt    = ST_IDLE;
        hold_cnt_nxt = '0;
      end
    endcase
  end

  // Game number: cleared when a ROM download starts, loaded by index-1 bytes.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      game_no <= '0;
    end else if (enter_load) begin
      game_no <= '0;
    end else if (ioctl_wr && (ioctl_index == 8'd1)) begin
      game_no <= ioctl_dout;
    end
  end

endmodule
